// File: rtl/pipe_exe_md.sv
// Execute stage with operand forwarding, ALU, and an iterative unsigned
// multiply/divide unit (HI/LO) that stalls dependent MD instructions.

module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [4:0]       i_aluc,
  output logic [WIDTH-1:0] o_r,
  output logic             o_z
);
  localparam int SH_W = $clog2(WIDTH);

  logic        [SH_W-1:0]  w_sh;
  logic signed [WIDTH-1:0] w_bs;

  assign w_sh = i_a[SH_W-1:0];
  assign w_bs = i_b;

  always_comb begin
    o_r = '0;
    case (i_aluc)
      5'd0:    o_r = i_a + i_b;
      5'd1:    o_r = i_a - i_b;
      5'd2:    o_r = i_a & i_b;
      5'd3:    o_r = i_a | i_b;
      5'd4:    o_r = i_a ^ i_b;
      5'd5:    o_r = {i_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      5'd6:    o_r = i_b << w_sh;
      5'd7:    o_r = i_b >> w_sh;
      5'd8:    o_r = w_bs >>> w_sh;
      5'd9:    o_r = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      5'd10:   o_r = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      default: o_r = '0;
    endcase
  end

  assign o_z = (o_r == '0);
endmodule

module pipe_exe_md #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             e_valid,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [WIDTH-1:0] eimm,
  input  logic [WIDTH-1:0] epc4,
  input  logic [4:0]       ern0,
  input  logic [4:0]       ealuc,
  input  logic             ejal,
  input  logic             ej,
  input  logic             ebeq,
  input  logic             ebne,
  input  logic [1:0]       eadepen,
  input  logic [1:0]       ebdepen,
  input  logic [1:0]       esdepen,
  input  logic [WIDTH-1:0] malu,
  input  logic [WIDTH-1:0] wdi,
  input  logic [2:0]       emd_op,
  output logic [WIDTH-1:0] ealu,
  output logic [WIDTH-1:0] ebs,
  output logic [4:0]       ern,
  output logic             z,
  output logic             ex_is_uncond,
  output logic             ex_is_cond,
  output logic             md_busy,
  output logic             e_stall
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIV0} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_opa, r_opb, r_acc, r_q;

  logic [WIDTH-1:0] w_a, w_b, w_sa, w_alu_r;
  logic             w_alu_z, w_issue, w_is_md, w_last;
  logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic [WIDTH-1:0] w_acc_nxt, w_q_nxt;

  // Operand forwarding
  assign w_sa = {eimm[4:0], eimm[WIDTH-1:5]};

  always_comb begin
    w_a = ea;
    case (eadepen)
      2'd1:    w_a = w_sa;
      2'd2:    w_a = malu;
      2'd3:    w_a = wdi;
      default: w_a = ea;
    endcase
    w_b = eb;
    case (ebdepen)
      2'd1:    w_b = eimm;
      2'd2:    w_b = malu;
      2'd3:    w_b = wdi;
      default: w_b = eb;
    endcase
    ebs = eb;
    case (esdepen)
      2'd1:    ebs = '0;
      2'd2:    ebs = malu;
      2'd3:    ebs = wdi;
      default: ebs = eb;
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_aluc (ealuc),
    .o_r    (w_alu_r),
    .o_z    (w_alu_z)
  );

  assign z = w_alu_z;

  always_comb begin
    if (ejal)                ealu = epc4 + WIDTH'(4);
    else if (emd_op == 3'd3) ealu = r_hi;
    else if (emd_op == 3'd4) ealu = r_lo;
    else                     ealu = w_alu_r;
  end

  assign md_busy = (r_state != S_IDLE);
  assign w_is_md = (emd_op >= 3'd1) && (emd_op <= 3'd4);
  assign e_stall = e_valid & md_busy & w_is_md;
  assign w_issue = e_valid & ((emd_op == 3'd1) | (emd_op == 3'd2)) & ~md_busy;
  assign w_last  = (r_cnt == CNT_W'(1));

  // Stalled slot is turned into a bubble for the next stage
  assign ern          = e_stall ? 5'd0 : (ern0 | {5{ejal}});
  assign ex_is_uncond = ~e_stall & (ej | ejal);
  assign ex_is_cond   = ~e_stall & ((w_alu_z & ebeq) | (~w_alu_z & ebne));

  // One shift-add / restoring-divide step on the working registers
  assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opa} : '0);
  assign w_div_shift = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};

  always_comb begin
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    if (r_state == S_MUL) begin
      w_acc_nxt = w_mul_sum[WIDTH:1];
      w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      if (!w_div_diff[WIDTH]) begin
        w_acc_nxt = w_div_diff[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_div_shift[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          if (emd_op == 3'd1)  w_state_nxt = S_MUL;
          else if (w_b == '0)  w_state_nxt = S_DIV0;
          else                 w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      S_DIV0:       w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_issue) r_cnt <= CNT_W'(WIDTH);
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_hi <= w_acc_nxt;
            r_lo <= w_q_nxt;
          end
        end
        S_DIV0: begin
          r_cnt <= '0;
          r_hi  <= r_opa;
          r_lo  <= DIV0_LO;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Working datapath registers carry no reset; the FSM gates their use
  always_ff @(posedge clock) begin
    if (w_issue) begin
      r_opa <= w_a;
      r_opb <= w_b;
      r_acc <= '0;
      r_q   <= (emd_op == 3'd1) ? w_b : w_a;
    end else if (md_busy) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
    end
  end
endmodule

// File: tb/tb_pipe_exe_md.sv
// Directed bench for pipe_exe_md: forwarding, jal/branch flags, MULTU/DIVU
// timing and results, MD stalls and asynchronous abort.

module tb_pipe_exe_md;
  localparam int W = 32;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;

  logic         clock, resetn, e_valid;
  logic [W-1:0] ea, eb, eimm, epc4, malu, wdi;
  logic [4:0]   ern0, ealuc;
  logic         ejal, ej, ebeq, ebne;
  logic [1:0]   eadepen, ebdepen, esdepen;
  logic [2:0]   emd_op;
  logic [W-1:0] ealu, ebs;
  logic [4:0]   ern;
  logic         z, ex_is_uncond, ex_is_cond, md_busy, e_stall;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_exe_md #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .e_valid(e_valid),
    .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4),
    .ern0(ern0), .ealuc(ealuc), .ejal(ejal), .ej(ej), .ebeq(ebeq), .ebne(ebne),
    .eadepen(eadepen), .ebdepen(ebdepen), .esdepen(esdepen),
    .malu(malu), .wdi(wdi), .emd_op(emd_op),
    .ealu(ealu), .ebs(ebs), .ern(ern), .z(z),
    .ex_is_uncond(ex_is_uncond), .ex_is_cond(ex_is_cond),
    .md_busy(md_busy), .e_stall(e_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an MD op at a negedge, then MFHI behind it; count busy cycles.
  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_cyc);
    int n;
    e_valid = 1'b1; emd_op = op; ea = a; eb = b;
    eadepen = 2'd0; ebdepen = 2'd0; ern0 = 5'd0; ejal = 1'b0;
    #1 check({tag, "_nostall_issue"}, e_stall, 1'b0);
    @(negedge clock);
    emd_op = 3'd3; ern0 = 5'd5;
    n = 0;
    while (md_busy && n < 100) begin
      #1;
      if (n == 0 || n == exp_cyc - 1) begin
        check({tag, "_stall"}, e_stall, 1'b1);
        check({tag, "_bubble_ern"}, ern, 5'd0);
      end
      n++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, n, exp_cyc);
    #1;
    check({tag, "_stall_released"}, e_stall, 1'b0);
    check({tag, "_mfhi_ern"}, ern, 5'd5);
  endtask

  initial begin
    resetn = 1'b0; e_valid = 1'b0;
    ea = '0; eb = '0; eimm = '0; epc4 = '0; malu = '0; wdi = '0;
    ern0 = '0; ealuc = ALU_ADD; ejal = 0; ej = 0; ebeq = 0; ebne = 0;
    eadepen = '0; ebdepen = '0; esdepen = '0; emd_op = '0;

    @(negedge clock);
    #1;
    check("rst_busy", md_busy, 1'b0);
    e_valid = 1'b1; emd_op = 3'd3;
    #1 check("rst_stall", e_stall, 1'b0);
    check("rst_mfhi", ealu, 32'h0);
    emd_op = 3'd4;
    #1 check("rst_mflo", ealu, 32'h0);
    emd_op = 3'd0;
    @(negedge clock);
    resetn = 1'b1;

    // Forwarding and jal
    eadepen = 2'd2; malu = 32'd5; ebdepen = 2'd3; wdi = 32'd7;
    ealuc = ALU_ADD; ern0 = 5'd9; esdepen = 2'd2;
    #1;
    check("fwd_add", ealu, 32'd12);
    check("fwd_ern", ern, 5'd9);
    check("fwd_ebs", ebs, 32'd5);
    check("fwd_z", z, 1'b0);
    check("fwd_uncond", ex_is_uncond, 1'b0);
    ejal = 1'b1; epc4 = 32'h100;
    #1;
    check("jal_ealu", ealu, 32'h104);
    check("jal_ern", ern, 5'd31);
    check("jal_uncond", ex_is_uncond, 1'b1);
    ejal = 1'b0;

    // Shift amount rotate and immediate B
    eadepen = 2'd1; ebdepen = 2'd1; eimm = 32'h3;
    #1 check("sa_imm_add", ealu, 32'h1800_0003);

    // beq on equal operands, zero store data
    eadepen = 2'd0; ebdepen = 2'd0; ea = 32'h55; eb = 32'h55;
    ealuc = ALU_SUB; ebeq = 1'b1; esdepen = 2'd1;
    #1;
    check("beq_z", z, 1'b1);
    check("beq_cond", ex_is_cond, 1'b1);
    check("ebs_zero", ebs, 32'h0);
    ebeq = 1'b0; ebne = 1'b1;
    #1 check("bne_cond", ex_is_cond, 1'b0);
    ebne = 1'b0; ealuc = ALU_ADD; esdepen = 2'd0;
    @(negedge clock);

    run_md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    check("multu_max_hi", ealu, 32'hFFFF_FFFE);
    emd_op = 3'd4;
    #1 check("multu_max_lo", ealu, 32'h0000_0001);
    e_valid = 1'b0; emd_op = 3'd0;
    @(negedge clock);

    run_md("divu_100_7", 3'd2, 32'd100, 32'd7, 32);
    check("divu_hi", ealu, 32'd2);
    emd_op = 3'd4;
    #1 check("divu_lo", ealu, 32'd14);
    e_valid = 1'b0; emd_op = 3'd0;
    @(negedge clock);

    run_md("divu_zero", 3'd2, 32'h1234, 32'h0, 1);
    check("div0_hi", ealu, 32'h1234);
    emd_op = 3'd4;
    #1 check("div0_lo", ealu, 32'hFFFF_FFFF);
    e_valid = 1'b0; emd_op = 3'd0;
    @(negedge clock);

    // Abort a MULTU mid-flight; a non-MD op runs unstalled meanwhile
    e_valid = 1'b1; emd_op = 3'd1; ea = 32'hFFFF_FFFF; eb = 32'hFFFF_FFFF;
    @(negedge clock);
    emd_op = 3'd0; ea = 32'd1; eb = 32'd2; ern0 = 5'd3;
    #1;
    check("abort_busy", md_busy, 1'b1);
    check("nonmd_nostall", e_stall, 1'b0);
    check("nonmd_ern", ern, 5'd3);
    check("nonmd_ealu", ealu, 32'd3);
    for (int i = 0; i < 9; i++) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort_busy_clr", md_busy, 1'b0);
    emd_op = 3'd3;
    #1;
    check("abort_stall", e_stall, 1'b0);
    check("abort_hi", ealu, 32'h0);
    emd_op = 3'd4;
    #1 check("abort_lo", ealu, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    run_md("multu_3x4", 3'd1, 32'd3, 32'd4, 32);
    check("multu_3x4_hi", ealu, 32'h0);
    emd_op = 3'd4;
    #1 check("multu_3x4_lo", ealu, 32'd12);
    e_valid = 1'b0; emd_op = 3'd0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
